// File: rtl/bfp_comp_blk.sv
// Block-floating-point compressor: ping-pong block buffer, one shared exponent per block, AXIS in/out.
// Define BFP_COMP_BLK_STATS_EN to add the stat_blocks / stat_max_exp outputs.
module bfp_comp_blk #(
    parameter int LANES       = 4,
    parameter int BLOCK_BEATS = 6,
    parameter int USER_WIDTH  = 32,
    parameter int UFIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES*16-1:0]   s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [LANES*16-1:0]   m_axis_tdata,
    output logic [3:0]            m_axis_texp,
    output logic                  m_axis_tfirst,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic [3:0]            ctrl_ud_comp_meth,
    input  logic [3:0]            ctrl_ud_iq_width,
    output logic                  err_partial
`ifdef BFP_COMP_BLK_STATS_EN
    ,
    output logic [31:0]           stat_blocks,
    output logic [3:0]            stat_max_exp
`endif
);

    localparam int DW  = LANES * 16;
    localparam int AW  = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
    localparam int UAW = $clog2(UFIFO_DEPTH);

    // need = (index of highest set magnitude bit) + 2; exponent is whatever exceeds the width
    function automatic logic [3:0] f_block_exp(input logic [15:0] or_v, input logic [4:0] w);
        logic [4:0] need;
        need = 5'd1;
        for (int i = 0; i < 16; i++)
            if (or_v[i]) need = 5'(i + 2);
        return (need > w) ? 4'(need - w) : 4'd0;
    endfunction

    function automatic logic [15:0] f_mant(input logic [15:0] s, input logic [3:0] e,
                                           input logic [4:0] w);
        logic [15:0] sh;
        logic [3:0]  msb;
        logic [15:0] res;
        sh  = 16'($signed(s) >>> e);
        msb = 4'(w - 5'd1);
        for (int i = 0; i < 16; i++)
            res[i] = (5'(i) < w) ? sh[i] : sh[msb];
        return res;
    endfunction

    logic [DW-1:0]         r_mem [2][BLOCK_BEATS];
    logic [1:0]            r_full;
    logic [1:0]            r_exp_rdy;
    logic [1:0]            r_last;
    logic [15:0]           r_or     [2];
    logic [3:0]            r_exp    [2];
    logic [4:0]            r_w      [2];
    logic [AW-1:0]         r_lastidx[2];

    logic                  r_wr_sel;
    logic [AW-1:0]         r_wr_cnt;
    logic                  r_pkt_first;
    logic                  r_err_partial;

    logic                  r_rd_sel;
    logic [AW-1:0]         r_rd_cnt;
    logic                  r_m_valid;
    logic [DW-1:0]         r_m_data;
    logic [3:0]            r_m_exp;
    logic                  r_m_first;
    logic                  r_m_last;

    logic [USER_WIDTH-1:0] r_uf_mem [UFIFO_DEPTH];
    logic [UAW:0]          r_uf_wp;
    logic [UAW:0]          r_uf_rp;

    logic                  w_uf_full;
    logic                  w_uf_empty;
    logic                  w_s_ready;
    logic                  w_s_fire;
    logic                  w_blk_end;
    logic                  w_wr_close;
    logic [4:0]            w_eff_w;
    logic [15:0]           w_beat_or;
    logic                  w_rd_load;
    logic                  w_rd_done;
    logic                  w_m_fire;
    logic [DW-1:0]         w_rd_word;
    logic [DW-1:0]         w_mant;

    assign w_uf_empty = (r_uf_wp == r_uf_rp);
    assign w_uf_full  = (r_uf_wp[UAW] != r_uf_rp[UAW]) &&
                        (r_uf_wp[UAW-1:0] == r_uf_rp[UAW-1:0]);

    // Only the first beat of a packet needs a free tuser slot.
    assign w_s_ready  = ~rst & ~r_full[r_wr_sel] & ~(w_uf_full & r_pkt_first);
    assign w_s_fire   = s_axis_tvalid & w_s_ready;
    assign w_blk_end  = (r_wr_cnt == AW'(BLOCK_BEATS - 1));
    assign w_wr_close = w_s_fire & (w_blk_end | s_axis_tlast);
    assign w_eff_w    = (ctrl_ud_comp_meth != 4'd1 || ctrl_ud_iq_width == 4'd0) ?
                        5'd16 : {1'b0, ctrl_ud_iq_width};

    // NOTE: every variable in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_beat_or = '0;
        for (int l = 0; l < LANES; l++)
            w_beat_or = w_beat_or | (s_axis_tdata[l*16 +: 16] ^ {16{s_axis_tdata[l*16+15]}});
    end

    assign w_rd_load = r_full[r_rd_sel] & r_exp_rdy[r_rd_sel] & (~r_m_valid | m_axis_tready);
    assign w_rd_done = w_rd_load & (r_rd_cnt == r_lastidx[r_rd_sel]);
    assign w_m_fire  = r_m_valid & m_axis_tready;

    always_comb begin
        w_rd_word = r_mem[r_rd_sel][r_rd_cnt];
        w_mant    = '0;
        for (int l = 0; l < LANES; l++)
            w_mant[l*16 +: 16] = f_mant(w_rd_word[l*16 +: 16], r_exp[r_rd_sel], r_w[r_rd_sel]);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_sel      <= 1'b0;
            r_wr_cnt      <= '0;
            r_pkt_first   <= 1'b1;
            r_err_partial <= 1'b0;
        end else if (w_s_fire) begin
            r_pkt_first <= s_axis_tlast;
            if (w_wr_close) begin
                r_wr_cnt <= '0;
                r_wr_sel <= ~r_wr_sel;
                if (s_axis_tlast && !w_blk_end) r_err_partial <= 1'b1;
            end else begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
        end
    end

    // NOTE: sample storage is not reset; the full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_s_fire) r_mem[r_wr_sel][r_wr_cnt] <= s_axis_tdata;
    end

    // Full is set on the closing beat; the exponent follows one cycle later from the settled OR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= '0;
            r_exp_rdy <= '0;
            r_last    <= '0;
            for (int b = 0; b < 2; b++) begin
                r_or[b]      <= '0;
                r_exp[b]     <= '0;
                r_w[b]       <= 5'd16;
                r_lastidx[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_s_fire && r_wr_sel == 1'(b)) begin
                    r_or[b] <= (r_wr_cnt == '0) ? w_beat_or : (r_or[b] | w_beat_or);
                    if (r_wr_cnt == '0) r_w[b] <= w_eff_w;
                    if (w_wr_close) begin
                        r_full[b]    <= 1'b1;
                        r_exp_rdy[b] <= 1'b0;
                        r_lastidx[b] <= r_wr_cnt;
                        r_last[b]    <= s_axis_tlast;
                    end
                end
                if (r_full[b] && !r_exp_rdy[b]) begin
                    r_exp[b]     <= f_block_exp(r_or[b], r_w[b]);
                    r_exp_rdy[b] <= 1'b1;
                end
                if (w_rd_done && r_rd_sel == 1'(b)) begin
                    r_full[b]    <= 1'b0;
                    r_exp_rdy[b] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_sel  <= 1'b0;
            r_rd_cnt  <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_exp   <= '0;
            r_m_first <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_rd_load) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_mant;
            r_m_exp   <= r_exp[r_rd_sel];
            r_m_first <= (r_rd_cnt == '0);
            r_m_last  <= r_last[r_rd_sel] & w_rd_done;
            if (w_rd_done) begin
                r_rd_cnt <= '0;
                r_rd_sel <= ~r_rd_sel;
            end else begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end else if (m_axis_tready) begin
            r_m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_uf_wp <= '0;
            r_uf_rp <= '0;
        end else begin
            if (w_s_fire && r_pkt_first) r_uf_wp <= r_uf_wp + 1'b1;
            if (w_m_fire && r_m_last)    r_uf_rp <= r_uf_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s_fire && r_pkt_first) r_uf_mem[r_uf_wp[UAW-1:0]] <= s_axis_tuser;
    end

`ifdef BFP_COMP_BLK_STATS_EN
    logic [31:0] r_stat_blocks;
    logic [3:0]  r_stat_max_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_blocks  <= '0;
            r_stat_max_exp <= '0;
        end else if (w_m_fire && r_m_first) begin
            r_stat_blocks <= r_stat_blocks + 32'd1;
            if (r_m_exp > r_stat_max_exp) r_stat_max_exp <= r_m_exp;
        end
    end

    assign stat_blocks  = r_stat_blocks;
    assign stat_max_exp = r_stat_max_exp;
`endif

    assign s_axis_tready = w_s_ready;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_texp   = r_m_exp;
    assign m_axis_tfirst = r_m_first;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tuser  = w_uf_empty ? '0 : r_uf_mem[r_uf_rp[UAW-1:0]];
    assign err_partial   = r_err_partial;

endmodule
